// File: rtl/sin_loader_pkg.sv
// Shared types and constants for the sine-table loader.
package sin_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  localparam int         WORD_BYTES  = 4;
  localparam int         TABLE_DEPTH = 256;
  localparam logic [3:0] FULL_MASK   = 4'hF;

  // Place one byte into its little-endian lane of a 32-bit word.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/sin_table_loader_if.sv
// Host byte stream, load control and SRAM port-0 bundle for the loader.
interface sin_table_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] count_m1;
  logic              abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              csb0;
  logic              web0;
  logic [3:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, count_m1, abort, byte_valid, byte_data,
    input  byte_ready, csb0, web0, wmask0, addr0, din0, busy, done
  );

  modport slave (
    input  start, start_addr, count_m1, abort, byte_valid, byte_data,
    output byte_ready, csb0, web0, wmask0, addr0, din0, busy, done
  );
endinterface

// File: rtl/sin_loader_assembler.sv
// Byte-to-word lane register: collects four little-endian bytes into one word.
module sin_loader_assembler
  import sin_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_lane,
  output logic        o_last
);
  logic [31:0] r_word;
  logic [1:0]  r_lane;

  // Lane counter and word register: clear restarts at lane 0, a load fills the current lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= 32'h0000_0000;
      r_lane <= 2'd0;
    end else if (i_clear) begin
      r_lane <= 2'd0;
    end else if (i_load) begin
      r_word <= insert_byte(r_word, r_lane, i_byte);
      r_lane <= r_lane + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_lane = r_lane;
  assign o_last = (r_lane == 2'(WORD_BYTES - 1));
endmodule

// File: rtl/sin_table_loader.sv
// Loads the sine/frequency SRAM from a host byte stream, one full word per WRITE cycle.
module sin_table_loader
  import sin_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  sin_table_loader_if.slave bus
);
  localparam int REM_W = $clog2(TABLE_DEPTH);

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr0;
  logic [REM_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_din0;
  logic              r_done;

  logic              w_byte_ready;
  logic              w_busy;
  logic              w_csb0;
  logic              w_web0;
  logic [3:0]        w_wmask0;
  logic              w_clear;
  logic              w_accept;
  logic              w_last;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic [31:0]       w_full_word;

  sin_loader_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_load  (w_accept),
    .i_byte  (bus.byte_data),
    .o_word  (w_word),
    .o_lane  (w_lane),
    .o_last  (w_last)
  );

  assign w_accept    = bus.byte_valid & w_byte_ready;
  // Word as it will look once the byte accepted this cycle lands (used for the last lane).
  assign w_full_word = insert_byte(w_word, w_lane, bus.byte_data);

  // State register; async reset drops port-0 strobes immediately via the state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: abort wins everywhere, WRITE always lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) w_next_state = COLLECT;
        else                         w_next_state = IDLE;
      end
      COLLECT: begin
        if (bus.abort)                 w_next_state = IDLE;
        else if (w_accept && w_last)   w_next_state = WRITE;
        else                           w_next_state = COLLECT;
      end
      WRITE: begin
        if (bus.abort || (r_rem == REM_W'(0))) w_next_state = IDLE;
        else                                   w_next_state = COLLECT;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode from the registered state only, so no input reaches an output.
  always_comb begin
    w_byte_ready = 1'b0;
    w_busy       = 1'b0;
    w_csb0       = 1'b1;
    w_web0       = 1'b1;
    w_wmask0     = 4'h0;
    w_clear      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
      end
      COLLECT: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        w_clear      = 1'b0;
      end
      WRITE: begin
        w_busy   = 1'b1;
        w_csb0   = 1'b0;
        w_web0   = 1'b0;
        w_wmask0 = FULL_MASK;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Address/remaining counters, held write address/data, and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= ADDR_W'(0);
      r_rem   <= REM_W'(0);
      r_addr0 <= ADDR_W'(0);
      r_din0  <= DATA_W'(0);
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_addr <= bus.start_addr;
            r_rem  <= bus.count_m1;
          end
        end
        COLLECT: begin
          if (!bus.abort && w_accept && w_last) begin
            r_addr0 <= r_addr;
            r_din0  <= w_full_word;
          end
        end
        WRITE: begin
          if (r_rem != REM_W'(0)) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rem  <= r_rem - REM_W'(1);
          end
        end
        default: begin
          r_addr <= r_addr;
        end
      endcase
      r_done <= (r_state == WRITE) && !bus.abort && (r_rem == REM_W'(0));
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.busy       = w_busy;
  assign bus.csb0       = w_csb0;
  assign bus.web0       = w_web0;
  assign bus.wmask0     = w_wmask0;
  assign bus.addr0      = r_addr0;
  assign bus.din0       = r_din0;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_sin_table_loader.sv
// Self-checking bench: SRAM port-0 model plus a stream-level reference of expected words.
module tb_sin_table_loader;
  logic clk = 1'b0;
  logic reset;

  sin_table_loader_if bus ();

  sin_table_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int viol = 0;

  logic [7:0]  stream [0:1023];
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [3:0]  wr_mask_q [$];
  int          wr_edge_q [$];
  logic [31:0] mem [0:255];
  bit          written [0:255];

  // Expected word i of the current stream: byte 4i is the least significant.
  function automatic logic [31:0] exp_word(input int i);
    return {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
  endfunction

  // SRAM port-0 model: commits a write on any edge where csb0 and web0 are low.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!bus.csb0 && !bus.web0) begin
      mem[bus.addr0]     = bus.din0;
      written[bus.addr0] = 1'b1;
      wr_addr_q.push_back(bus.addr0);
      wr_data_q.push_back(bus.din0);
      wr_mask_q.push_back(bus.wmask0);
      wr_edge_q.push_back(cyc);
      if (bus.byte_ready) viol = viol + 1;
    end
  end

  // Done pulse monitor: counts done cycles; busy must be low while done is high.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt = done_cnt + 1;
      if (bus.busy) viol = viol + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_mask_q.delete();
    wr_edge_q.delete();
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    done_cnt = 0;
    viol = 0;
  endtask

  task automatic start_load(input logic [7:0] addr, input logic [7:0] cm1);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = addr;
    bus.count_m1   = cm1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Feed n stream bytes; returns at the negedge after the last accepted byte.
  task automatic feed(input int n, input int stall_pct, input int abort_at, input int glitch_at,
                      output int first_edge, output bit timeout);
    int idx;
    int guard;
    bit glitched;
    idx = 0; guard = 0; glitched = 1'b0; first_edge = -1; timeout = 1'b0;
    while (idx < n) begin
      if (guard >= 5000) begin
        timeout = 1'b1;
        break;
      end
      guard++;
      if (abort_at >= 0 && idx == abort_at) begin
        bus.abort      = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        break;
      end
      if (glitch_at >= 0 && idx == glitch_at && !glitched) begin
        bus.start      = 1'b1;
        bus.start_addr = bus.start_addr + 8'h80;
        bus.count_m1   = 8'd7;
        glitched       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      bus.byte_valid = ($urandom_range(99) >= stall_pct);
      bus.byte_data  = stream[idx];
      if (bus.byte_valid && bus.byte_ready) begin
        if (idx == 0) first_edge = cyc + 1;
        idx++;
      end
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
  endtask

  task automatic wait_idle(output bit timeout);
    timeout = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.csb0, bus.web0, bus.wmask0} !== 6'b11_0000) begin
      failures++;
      $display("FAIL reset_strobes: got csb0/web0/wmask0=%b required 110000", {bus.csb0, bus.web0, bus.wmask0});
    end
    checks++;
    if ({bus.addr0, bus.din0} !== 40'h0) begin
      failures++;
      $display("FAIL reset_bus: got addr0=%h din0=%h required 0/0", bus.addr0, bus.din0);
    end
    checks++;
    if ({bus.byte_ready, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got ready/busy/done=%b required 000", {bus.byte_ready, bus.busy, bus.done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.byte_ready, bus.busy, bus.csb0} !== 3'b001) begin
      failures++;
      $display("FAIL idle_after_reset: got ready/busy/csb0=%b required 001", {bus.byte_ready, bus.busy, bus.csb0});
    end
  endtask

  task automatic test_single_word();
    int first; bit to; bit got; int d_edge;
    clear_model();
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    start_load(8'h10, 8'd0);
    feed(4, 0, -1, -1, first, to);
    checks++;
    if (to) begin failures++; $display("FAIL single_feed_timeout: got timeout required none"); end
    checks++;
    if ({bus.csb0, bus.web0, bus.wmask0, bus.addr0, bus.din0, bus.byte_ready} !==
        {1'b0, 1'b0, 4'hF, 8'h10, 32'h44332211, 1'b0}) begin
      failures++;
      $display("FAIL single_write_port: got csb0=%b web0=%b wmask0=%h addr0=%h din0=%h ready=%b required 0 0 F 10 44332211 0",
               bus.csb0, bus.web0, bus.wmask0, bus.addr0, bus.din0, bus.byte_ready);
    end
    got = 1'b0; d_edge = -1;
    for (int k = 0; k < 50; k++) begin
      if (bus.done) begin got = 1'b1; d_edge = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (!got || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got done_seen=%0d busy=%b required 1 0", got, bus.busy);
    end
    checks++;
    if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 8'h10 || wr_data_q[0] !== 32'h44332211 || wr_mask_q[0] !== 4'hF) begin
      failures++;
      $display("FAIL single_sram: got %0d writes required one full write 44332211 at 10", wr_addr_q.size());
    end
    checks++;
    if (wr_edge_q.size() < 1 || d_edge !== wr_edge_q[0]) begin
      failures++;
      $display("FAIL single_done_timing: got done edge %0d required %0d", d_edge, (wr_edge_q.size() > 0) ? wr_edge_q[0] : -1);
    end
    // back-to-back: new start in the done cycle
    bus.start = 1'b1; bus.start_addr = 8'h20; bus.count_m1 = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.byte_ready !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_start: got ready=%b busy=%b required 1 1", bus.byte_ready, bus.busy);
    end
    for (int i = 0; i < 4; i++) stream[i] = 8'($urandom);
    feed(4, 0, -1, -1, first, to);
    wait_idle(to);
    checks++;
    if (to || wr_addr_q.size() !== 2 || done_cnt !== 2) begin
      failures++;
      $display("FAIL back_to_back_count: got writes=%0d dones=%0d required 2 2", wr_addr_q.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr_q[1] !== 8'h20 || wr_data_q[1] !== exp_word(0)) begin
        failures++;
        $display("FAIL back_to_back_data: got %h@%h required %h@20", wr_data_q[1], wr_addr_q[1], exp_word(0));
      end
    end
  endtask

  task automatic test_wrap();
    int first; bit to; bit got; int d_edge;
    logic [7:0] ea;
    clear_model();
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    start_load(8'hFE, 8'd3);
    feed(16, 0, -1, -1, first, to);
    got = 1'b0; d_edge = -1;
    for (int k = 0; k < 50; k++) begin
      if (bus.done) begin got = 1'b1; d_edge = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (to || !got || (d_edge - first + 1) !== 20) begin
      failures++;
      $display("FAIL wrap_latency: got %0d cycles (done_seen=%0d) required 20", d_edge - first + 1, got);
    end
    wait_idle(to);
    checks++;
    if (wr_addr_q.size() !== 4 || done_cnt !== 1) begin
      failures++;
      $display("FAIL wrap_count: got writes=%0d dones=%0d required 4 1", wr_addr_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ea = 8'hFE + 8'(i);
        checks++;
        if (wr_addr_q[i] !== ea || wr_data_q[i] !== exp_word(i)) begin
          failures++;
          $display("FAIL wrap_word%0d: got %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_word(i), ea);
        end
      end
    end
  endtask

  task automatic test_host_stalls();
    int first; bit to; int bad;
    logic [7:0] base; logic [7:0] ea;
    clear_model();
    base = 8'($urandom);
    for (int i = 0; i < 1024; i++) stream[i] = 8'($urandom);
    start_load(base, 8'd255);
    feed(1024, 40, -1, -1, first, to);
    checks++;
    if (to) begin failures++; $display("FAIL stall_feed_timeout: got timeout required none"); end
    wait_idle(to);
    checks++;
    if (to || wr_addr_q.size() !== 256 || done_cnt !== 1) begin
      failures++;
      $display("FAIL stall_count: got writes=%0d dones=%0d required 256 1", wr_addr_q.size(), done_cnt);
    end
    bad = 0;
    for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
      ea = base + 8'(i);
      if (wr_addr_q[i] !== ea || wr_data_q[i] !== exp_word(i)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_write_order: got %0d wrong writes required 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      ea = base + 8'(i);
      if (!written[ea] || mem[ea] !== exp_word(i)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_sram_contents: got %0d wrong words required 0", bad);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL stall_ready_in_write: got %0d violations required 0", viol);
    end
  endtask

  task automatic test_abort_and_ignored_start();
    int first; bit to; int bad;
    logic [7:0] base; logic [7:0] ea;
    clear_model();
    base = 8'($urandom);
    for (int i = 0; i < 24; i++) stream[i] = 8'($urandom);
    start_load(base, 8'd5);
    feed(24, 20, 14, -1, first, to);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || wr_addr_q.size() !== 3 || done_cnt !== 0) begin
      failures++;
      $display("FAIL abort_state: got busy=%b writes=%0d dones=%0d required 0 3 0", bus.busy, wr_addr_q.size(), done_cnt);
    end
    bad = 0;
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      ea = base + 8'(i);
      if (wr_addr_q[i] !== ea || wr_data_q[i] !== exp_word(i)) bad++;
    end
    ea = base + 8'd3;
    checks++;
    if (bad !== 0 || written[ea]) begin
      failures++;
      $display("FAIL abort_words: got %0d wrong, word3 written=%0d required 0 0", bad, written[ea]);
    end
    // start pulsed while busy must not disturb the load
    clear_model();
    base = 8'($urandom);
    for (int i = 0; i < 8; i++) stream[i] = 8'($urandom);
    start_load(base, 8'd1);
    feed(8, 30, -1, 6, first, to);
    wait_idle(to);
    checks++;
    if (to || wr_addr_q.size() !== 2 || done_cnt !== 1) begin
      failures++;
      $display("FAIL ignored_start_count: got writes=%0d dones=%0d required 2 1", wr_addr_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 2; i++) begin
        ea = base + 8'(i);
        checks++;
        if (wr_addr_q[i] !== ea || wr_data_q[i] !== exp_word(i)) begin
          failures++;
          $display("FAIL ignored_start_word%0d: got %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_word(i), ea);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int first; bit to;
    clear_model();
    for (int i = 0; i < 4; i++) stream[i] = 8'($urandom);
    start_load(8'h40, 8'd0);
    feed(4, 0, -1, -1, first, to);
    checks++;
    if (bus.csb0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_in_write: got csb0=%b required 0", bus.csb0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.csb0, bus.web0, bus.busy} !== 3'b110) begin
      failures++;
      $display("FAIL midreset_async: got csb0/web0/busy=%b required 110", {bus.csb0, bus.web0, bus.busy});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 0 || written[8'h40] || done_cnt !== 0) begin
      failures++;
      $display("FAIL midreset_no_write: got writes=%0d written40=%0d dones=%0d required 0 0 0",
               wr_addr_q.size(), written[8'h40], done_cnt);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.start_addr = 8'h00;
    bus.count_m1   = 8'h00;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_single_word();
    test_wrap();
    test_host_stalls();
    test_abort_and_ignored_start();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sin_table_loader.md
# sin_table_loader

Host-side loader that fills the 256 x 32 sine/frequency lookup SRAM (sky130 1 KB macro) that the phase counter reads on its read port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It issues one full-word write per word on SRAM port 0 (csb0/web0/wmask0/addr0/din0), auto-incrementing from a start address. It reports busy/done so the system can hold the counter in preload while the table is rewritten.

## Interface
Parameters:
- ADDR_W, 8, SRAM word address width; only the default is supported.
- DATA_W, 32, SRAM word width; only the default is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- start_addr  in  8  first SRAM word address, latched on an accepted start.
- count_m1  in  8  number of words minus 1 (0 = 1 word, 255 = 256 words), latched on an accepted start.
- abort  in  1  cancels the load; a partially assembled word is discarded.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- csb0  out  1  SRAM port 0 chip select, active-low.
- web0  out  1  SRAM port 0 write enable, active-low.
- wmask0  out  4  SRAM byte write mask.
- addr0  out  8  SRAM write address.
- din0  out  32  SRAM write data.
- busy  out  1  load in progress (COLLECT or WRITE).
- done  out  1  one-cycle pulse after the final word is written.

## Operation
- FSM states:
  - IDLE:
    - byte_ready = 0, busy = 0.
    - start & !abort: latch start_addr, latch count_m1, lane = 0, go to COLLECT.
  - COLLECT:
    - byte_ready = 1, busy = 1.
    - On each byte_valid & byte_ready, byte_data goes into word[8*lane +: 8]; the first byte lands in bits 7:0. lane increments.
    - Accepting the byte with lane = 3 goes to WRITE.
  - WRITE (exactly one cycle):
    - byte_ready = 0, busy = 1.
    - Port 0 driven with csb0 = 0, web0 = 0, wmask0 = 4'hF, addr0 = current address, din0 = assembled word.
    - If remaining = 0: go to IDLE and pulse done.
    - Otherwise: address + 1, remaining − 1, lane = 0, go to COLLECT.
- Address arithmetic is mod 256: 8'hFF + 1 = 8'h00. A load may wrap.
- Outside WRITE: csb0 = 1, web0 = 1, wmask0 = 0. addr0/din0 hold their last values.
- All port-0 outputs, byte_ready, busy and done come from flops or a registered-state decode; no combinational path from any input.
- start while busy is ignored.
- abort:
  - In COLLECT: go to IDLE at the next edge; no write, no done.
  - In WRITE: the write in that cycle still completes, then go to IDLE; no done.
  - In IDLE: has priority over start.
- byte_valid in IDLE or WRITE is not consumed; the host must hold the byte.

## Timing
- Reset values: state IDLE, csb0 = 1, web0 = 1, wmask0 = 0, addr0 = 0, din0 = 0, byte_ready = 0, busy = 0, done = 0.
- Reset asserted mid-load forces csb0/web0 high asynchronously. No write is committed on any edge while reset is high.
- start accepted at edge E: byte_ready = 1 from E.
- 4th byte of a word accepted at edge N: WRITE occupies cycle N..N+1, and the SRAM samples the write at edge N+1. byte_ready is 0 in that cycle and returns to 1 after N+1.
- Peak throughput: 5 cycles per word.
- done = 1 for exactly the one cycle after the final WRITE cycle. busy = 0 in that same cycle.
- A new start is accepted in the cycle done is high.

## Structure
- Package sin_loader_pkg holds:
  - state enum {IDLE, COLLECT, WRITE};
  - WORD_BYTES = 4;
  - TABLE_DEPTH = 256;
  - FULL_MASK = 4'hF.
- Sub-module sin_loader_assembler: byte-to-word lane register plus 2-bit lane counter, with clear and last-byte flag. The top holds the FSM, address and remaining counters, and the port-0 drivers.

## Test plan
- Reset mid-load:
  - Stimulus: assert reset during WRITE.
  - Required: csb0 = 1 and web0 = 1 immediately; busy = 0; SRAM model shows no write at that address.
- Single word:
  - Stimulus: start_addr = 8'h10, count_m1 = 0, bytes 0x11, 0x22, 0x33, 0x44 at full rate.
  - Required: one write, addr0 = 8'h10, din0 = 32'h44332211, wmask0 = 4'hF; done pulses once, 1 cycle after the write.
- Wrap-around:
  - Stimulus: start_addr = 8'hFE, count_m1 = 3.
  - Required: writes in order to FE, FF, 00, 01; total 20 cycles from first byte accepted to done at full rate.
- Host stalls:
  - Stimulus: byte_valid toggled randomly over 256 words.
  - Required: every SRAM word matches the stream; byte_ready never high in WRITE; exactly 256 write cycles.
- Abort and ignored start:
  - Stimulus: abort after 2 bytes of word 3.
  - Required: words 0–2 written; no write of word 3; no done.
  - Stimulus: start pulsed while busy.
  - Required: ignored; latched address is unchanged.
